// File: rtl/internal_ram_arbiter_pkg.sv
// Shared definitions for the on-chip RAM path: geometry, ROM/RAM split and the
// per-port request bundle used by the arbiter, RAM wrapper and bus adapters.
package internal_ram_pkg;

  localparam int RAM_ADDR_W  = 11;
  localparam int RAM_DATA_W  = 64;
  localparam int RAM_MASK_W  = 8;
  localparam int ROM_SEL_BIT = 10;

  typedef struct packed {
    logic                  wr;
    logic                  lock;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_MASK_W-1:0] mask;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

  // Lower half of the word space is boot ROM; writes there are dropped.
  function automatic logic is_rom_write(ram_req_t r);
    return r.wr && !r.addr[ROM_SEL_BIT];
  endfunction

endpackage

// File: rtl/internal_ram_arbiter_rr.sv
// Round-robin pick starting after last_grant; hold_i re-grants last_grant
// (the caller guarantees that port is still valid).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_grant_i,
  input  logic          hold_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = last_grant_i;
    any_o       = 1'b0;
    idx         = 0;
    if (hold_i) begin
      any_o = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last_grant_i) + k) % N;
        if (!any_o && valid_i[idx]) begin
          any_o       = 1'b1;
          grant_idx_o = IW'(idx);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_o[i] = any_o && (int'(grant_idx_o) == i);
    end
  end

endmodule

// File: rtl/internal_ram_arbiter.sv
// Shares the single-port on-chip RAM between NUM_PORTS requesters with
// round-robin arbitration, bounded lock bursts and boot-ROM write protection.
module internal_ram_arbiter
  import internal_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS-1:0]      req_wr,
  input  logic [NUM_PORTS-1:0]      req_lock,
  input  logic [NUM_PORTS*11-1:0]   req_addr,
  input  logic [NUM_PORTS*8-1:0]    req_mask,
  input  logic [NUM_PORTS*64-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]      rsp_valid,
  output logic                      rsp_err,
  output logic [RAM_DATA_W-1:0]     rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_wr,
  output logic [RAM_ADDR_W-1:0]     ram_addr,
  output logic [RAM_MASK_W-1:0]     ram_mask,
  output logic [RAM_DATA_W-1:0]     ram_wdata,
  input  logic [RAM_DATA_W-1:0]     ram_rdata
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  ram_req_t          req [NUM_PORTS];
  ram_req_t          sel;
  logic [NUM_PORTS-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              any_grant;
  logic              hold;
  logic              rom_drop;

  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              locked_q, locked_d;
  logic              rsp_pending_q, rsp_pending_d;
  logic [IW-1:0]     rsp_port_q, rsp_port_d;
  logic              rom_err_q, rom_err_d;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i].wr    = req_wr[i];
      req[i].lock  = req_lock[i];
      req[i].addr  = req_addr[i*RAM_ADDR_W +: RAM_ADDR_W];
      req[i].mask  = req_mask[i*RAM_MASK_W +: RAM_MASK_W];
      req[i].wdata = req_wdata[i*RAM_DATA_W +: RAM_DATA_W];
    end
  end

  // Lock is honoured only while the holder stays valid and under the burst cap.
  assign hold = locked_q && req_valid[last_grant_q] && (burst_cnt_q < 4'(MAX_BURST));

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .hold_i       (hold),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (any_grant)
  );

  assign sel      = any_grant ? req[grant_idx] : '0;
  assign rom_drop = is_rom_write(sel);

  assign req_ready = grant;
  assign ram_en    = any_grant && !rom_drop;
  assign ram_wr    = ram_en && sel.wr;
  assign ram_addr  = sel.addr;
  assign ram_mask  = sel.mask;
  assign ram_wdata = sel.wdata;

  always_comb begin
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    locked_d      = 1'b0;
    rsp_pending_d = any_grant;
    rsp_port_d    = rsp_port_q;
    rom_err_d     = rom_drop;
    if (any_grant) begin
      last_grant_d = grant_idx;
      rsp_port_d   = grant_idx;
      locked_d     = sel.lock;
      // A grant won by arbitration (including a forced rotation back to the
      // same port at the burst cap) starts a fresh burst.
      if (hold) burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
      else      burst_cnt_d = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= IW'(NUM_PORTS - 1);
      burst_cnt_q   <= 4'd0;
      locked_q      <= 1'b0;
      rsp_pending_q <= 1'b0;
      rsp_port_q    <= '0;
      rom_err_q     <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      locked_q      <= locked_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_port_q    <= rsp_port_d;
      rom_err_q     <= rom_err_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pending_q) rsp_valid[rsp_port_q] = 1'b1;
  end

  assign rsp_err   = rsp_pending_q && rom_err_q;
  assign rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_internal_ram_arbiter.sv
// Self-checking bench for internal_ram_arbiter: behavioural RAM, a rule-level
// reference model, directed scenarios and randomized traffic.
module tb_internal_ram_arbiter;

  localparam int NP = 2;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NP-1:0]     req_valid, req_ready, req_wr, req_lock, rsp_valid;
  logic [NP*11-1:0]  req_addr;
  logic [NP*8-1:0]   req_mask;
  logic [NP*64-1:0]  req_wdata;
  logic              rsp_err;
  logic [63:0]       rsp_rdata;
  logic              ram_en, ram_wr;
  logic [10:0]       ram_addr;
  logic [7:0]        ram_mask;
  logic [63:0]       ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  internal_ram_arbiter #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [63:0] tb_mem  [2048];
  logic [63:0] mdl_mem [2048];

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) o[b*8 +: 8] = n[b*8 +: 8];
    return o;
  endfunction

  // Write-first single-port RAM; output holds when not enabled.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        tb_mem[ram_addr] = merge(tb_mem[ram_addr], ram_wdata, ram_mask);
        ram_rdata <= tb_mem[ram_addr];
      end else begin
        ram_rdata <= tb_mem[ram_addr];
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  int m_last, m_burst, m_port;
  bit m_locked, m_pend, m_err, m_rd;
  logic [63:0] m_rdata;

  logic [NP-1:0] c_ready, c_rsp_valid;
  logic          c_en, c_err;
  logic [63:0]   c_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = NP - 1; m_burst = 0; m_locked = 0;
    m_pend = 0; m_err = 0; m_rd = 0; m_port = 0;
  endtask

  task automatic idle();
    req_valid = '0; req_wr = '0; req_lock = '0;
    req_addr = '0; req_mask = '0; req_wdata = '0;
  endtask

  task automatic set_port(input int p, input bit v, input bit w, input bit l,
                          input logic [10:0] a, input logic [7:0] m, input logic [63:0] d);
    req_valid[p] = v; req_wr[p] = w; req_lock[p] = l;
    req_addr[p*11 +: 11] = a; req_mask[p*8 +: 8] = m; req_wdata[p*64 +: 64] = d;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances model at the edge.
  task automatic cycle();
    int g, idx;
    bit hold, w, drop;
    logic [10:0] a;
    logic [7:0]  m;
    logic [63:0] d;
    logic [NP-1:0] er, ev;
    #3;
    hold = m_locked && req_valid[m_last] && (m_burst < MB);
    g = -1;
    if (hold) g = m_last;
    else for (int k = 1; k <= NP; k++) begin
      idx = (m_last + k) % NP;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = '0; a = '0; m = '0; d = '0; w = 0; drop = 0;
    if (g >= 0) begin
      er[g] = 1'b1;
      a = req_addr[g*11 +: 11]; m = req_mask[g*8 +: 8]; d = req_wdata[g*64 +: 64];
      w = req_wr[g]; drop = w && !a[10];
    end
    c_ready = req_ready; c_rsp_valid = rsp_valid; c_en = ram_en;
    c_err = rsp_err; c_rdata = rsp_rdata;
    chk("req_ready", req_ready, er);
    chk("ram_en", ram_en, (g >= 0) && !drop);
    chk("ram_wr", ram_wr, (g >= 0) && !drop && w);
    chk("ram_addr", ram_addr, a);
    chk("ram_mask", ram_mask, m);
    chk("ram_wdata", ram_wdata, d);
    ev = '0;
    if (m_pend) ev[m_port] = 1'b1;
    chk("rsp_valid", rsp_valid, ev);
    if (m_pend) chk("rsp_err", rsp_err, m_err);
    if (m_pend && m_rd) chk("rsp_rdata", rsp_rdata, m_rdata);
    @(posedge clk);
    if (g >= 0) begin
      m_burst  = hold ? ((m_burst == 15) ? 15 : m_burst + 1) : 1;
      m_locked = req_lock[g];
      m_last = g; m_port = g; m_pend = 1; m_err = drop; m_rd = !w;
      m_rdata = mdl_mem[a];
      if (w && !drop) mdl_mem[a] = merge(mdl_mem[a], d, m);
    end else begin
      m_pend = 0; m_err = 0; m_locked = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    #2;
    chk("reset rsp_valid", rsp_valid, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  logic [NP-1:0] exp4 [4];
  logic [NP-1:0] exp5 [6];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      tb_mem[i]  = {32'hB007C0DE, 21'h0, 11'(i)};
      mdl_mem[i] = {32'hB007C0DE, 21'h0, 11'(i)};
    end
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    cycle();
    chk("reset ready", c_ready, '0);
    chk("reset rsp", c_rsp_valid, '0);

    // Test 1: ROM read on port 0
    set_port(0, 1, 0, 0, 11'h010, 8'hFF, 64'h0);
    cycle();
    chk("t1 ready", c_ready, 2'b01);
    idle();
    cycle();
    chk("t1 rsp_valid", c_rsp_valid, 2'b01);
    chk("t1 rdata", c_rdata, 64'hB007C0DE_00000010);

    // Test 2: masked RAM write then readback
    set_port(1, 1, 1, 0, 11'h400, 8'h0F, 64'h1122334455667788);
    cycle();
    idle();
    set_port(1, 1, 0, 0, 11'h400, 8'hFF, 64'h0);
    cycle();
    chk("t2 wr rsp_valid", c_rsp_valid, 2'b10);
    chk("t2 wr err", c_err, 1'b0);
    idle();
    cycle();
    chk("t2 rdata", c_rdata, 64'hB007C0DE_55667788);

    // Test 3: ROM write is dropped
    set_port(1, 1, 1, 0, 11'h3FF, 8'hFF, 64'hDEADBEEFDEADBEEF);
    cycle();
    chk("t3 ram_en", c_en, 1'b0);
    idle();
    set_port(1, 1, 0, 0, 11'h3FF, 8'hFF, 64'h0);
    cycle();
    chk("t3 rsp_valid", c_rsp_valid, 2'b10);
    chk("t3 err", c_err, 1'b1);
    idle();
    cycle();
    chk("t3 rdata", c_rdata, 64'hB007C0DE_000003FF);

    // Test 4: alternating grants
    do_reset();
    exp4 = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 0, 0, 11'(i), 8'hFF, 64'h0);
      set_port(1, 1, 0, 0, 11'(12'h400 + i), 8'hFF, 64'h0);
      cycle();
      chk("t4 grant", c_ready, exp4[i]);
    end
    idle();
    cycle();

    // Test 5: bounded lock burst
    do_reset();
    exp5 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    set_port(0, 1, 0, 1, 11'h410, 8'hFF, 64'h0);
    set_port(1, 1, 0, 0, 11'h420, 8'hFF, 64'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t5 grant", c_ready, exp5[i]);
    end
    idle();
    set_port(1, 1, 0, 1, 11'h430, 8'hFF, 64'h0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("t5 solo grant", c_ready, 2'b10);
    end
    idle();
    cycle();

    // Test 6: reset right after an accepted read
    set_port(0, 1, 0, 0, 11'h011, 8'hFF, 64'h0);
    cycle();
    do_reset();
    cycle();
    chk("t6 no rsp", c_rsp_valid, '0);
    set_port(0, 1, 0, 0, 11'h012, 8'hFF, 64'h0);
    set_port(1, 1, 0, 0, 11'h412, 8'hFF, 64'h0);
    cycle();
    chk("t6 grant", c_ready, 2'b01);
    idle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        for (int p = 0; p < NP; p++) begin
          set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 1,
                   {1'($urandom_range(0, 1)), 6'h0, 4'($urandom_range(0, 15))},
                   8'($urandom), {$urandom, $urandom});
        end
        cycle();
      end
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
